// File: rtl/xor_frame_checker.sv
// Streaming XOR checksum/parity/length unit, one result per frame over valid/ready.
// Optional XOR_CHK_COMPARE_EN adds in_expected/out_match checksum comparison.
module xor_frame_checker #(
  parameter int  WIDTH   = 8,
  parameter int  MAX_LEN = 16,
  localparam int LEN_W   = $clog2(MAX_LEN+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
`ifdef XOR_CHK_COMPARE_EN
  input  logic [WIDTH-1:0] in_expected,
  output logic             out_match,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_checksum,
  output logic             out_parity,
  output logic [LEN_W-1:0] out_len,
  output logic             out_overflow
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [LEN_W-1:0] len, len_nxt;
  logic             ovf, ovf_nxt;
  logic             in_xfer, out_xfer;

  assign in_ready     = (state != HOLD);
  assign out_valid    = (state == HOLD);
  assign in_xfer      = in_valid & in_ready;
  assign out_xfer     = out_valid & out_ready;
  assign out_checksum = acc;
  assign out_parity   = ^acc;
  assign out_len      = len;
  assign out_overflow = ovf;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    len_nxt   = len;
    ovf_nxt   = ovf;
    case (state)
      IDLE: if (in_xfer) begin
        acc_nxt   = in_data;
        len_nxt   = LEN_W'(1);
        ovf_nxt   = 1'b0;
        state_nxt = in_last ? HOLD : ACCUM;
      end
      ACCUM: if (in_xfer) begin
        acc_nxt = acc ^ in_data;
        // Count saturates; words past MAX_LEN still fold into the checksum
        if (len < LEN_W'(MAX_LEN)) len_nxt = len + LEN_W'(1);
        else                       ovf_nxt = 1'b1;
        state_nxt = in_last ? HOLD : ACCUM;
      end
      HOLD: if (out_xfer) begin
        acc_nxt   = '0;
        len_nxt   = '0;
        ovf_nxt   = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      len   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      len   <= len_nxt;
      ovf   <= ovf_nxt;
    end
  end

`ifdef XOR_CHK_COMPARE_EN
  logic match_nxt;

  always_comb begin
    match_nxt = out_match;
    if (in_xfer && in_last) match_nxt = (acc_nxt == in_expected);
    if (out_xfer)           match_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_match <= 1'b0;
    else        out_match <= match_nxt;
  end
`endif

endmodule
